// File: rtl/bta_operand_scheduler_pkg.sv
// Shared definitions for the BTA operand scheduler: default sizes, FSM state
// encodings and the operand-slot -> adder-bus mapping helpers.
// Ports: none (package).
package bta_pkg;

   localparam int N_DEF = 16;   // operands per batch
   localparam int M_DEF = 16;   // operand width

   // Scheduler FSM states (plain constants so older tools can read them)
   localparam logic [1:0] ST_FILL = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // Each of the four adder buses carries n/4 consecutive slots, lowest slot
   // in the least significant lane.
   function automatic int slot_bus(input int k, input int n);
      return k / (n / 4);
   endfunction

   function automatic int slot_lsb(input int k, input int n, input int m);
      return (k % (n / 4)) * m;
   endfunction

endpackage

// File: rtl/bta_operand_scheduler.sv
// Purpose: packs a valid/ready operand stream into the four tree-adder operand
//   buses, waits the adder latency, then captures and returns the batch sum.
// Latency: result valid ADD_LAT+1 edges after the final operand handshake.
// Backpressure: i_in_valid only accepted in FILL; result held until out handshake.
// Ports:
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_in_valid/o_in_ready    operand handshake; i_in_data operand, i_in_last end of batch
//   o_add_a..o_add_d         registered adder operand buses, o_add_c0 carry-in (0)
//   i_add_sum, i_add_carry   adder result and carry-out
//   o_out_valid/i_out_ready  result handshake; o_out_sum, o_out_count, o_out_ovf
//   o_busy                   scheduler not accepting operands (state != FILL)
module bta_operand_scheduler
   import bta_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int M       = M_DEF,
   parameter int ADD_LAT = 2
)(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_in_valid,
   output logic                       o_in_ready,
   input  logic [M-1:0]               i_in_data,
   input  logic                       i_in_last,
   output logic [M*N/4-1:0]           o_add_a,
   output logic [M*N/4-1:0]           o_add_b,
   output logic [M*N/4-1:0]           o_add_c,
   output logic [M*N/4-1:0]           o_add_d,
   output logic                       o_add_c0,
   input  logic [M+$clog2(N)-1:0]     i_add_sum,
   input  logic                       i_add_carry,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [M+$clog2(N)-1:0]     o_out_sum,
   output logic [$clog2(N+1)-1:0]     o_out_count,
   output logic                       o_out_ovf,
   output logic                       o_busy
);

   localparam int SW = M + $clog2(N);
   localparam int CW = $clog2(N + 1);
   localparam int BW = M * N / 4;
   localparam int LW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

   logic [1:0]    r_state;
   logic [M-1:0]  r_slot [N];
   logic [CW-1:0] r_count;
   logic [LW-1:0] r_lat;
   logic          r_out_valid;
   logic [SW-1:0] r_out_sum;
   logic [CW-1:0] r_out_count;
   logic          r_out_ovf;

   logic          w_in_hs;
   logic          w_out_hs;
   logic          w_last;
   logic [BW-1:0] w_bus [4];

   // in_ready is forced low while reset is asserted, not just one edge later
   assign o_in_ready = i_rst_n & (r_state == ST_FILL);
   assign w_in_hs    = i_in_valid & o_in_ready;
   assign w_out_hs   = r_out_valid & i_out_ready & (r_state == ST_HOLD);
   // the Nth operand closes the batch whether or not in_last is set
   assign w_last     = i_in_last | (r_count == CW'(N - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_FILL;
         r_count     <= '0;
         r_lat       <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_in_hs) begin
                  r_count <= r_count + 1'b1;
                  if (w_last) begin
                     r_state <= ST_WAIT;
                     r_lat   <= LW'(ADD_LAT);
                  end
               end
            end
            ST_WAIT: begin
               // buses are frozen here; sum is settled once the counter drains
               if (r_lat == '0) begin
                  r_out_sum   <= i_add_sum;
                  r_out_count <= r_count;
                  r_out_ovf   <= i_add_carry;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_HOLD;
               end else begin
                  r_lat <= r_lat - 1'b1;
               end
            end
            ST_HOLD: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_count     <= '0;
                  r_state     <= ST_FILL;
               end
            end
            default: r_state <= ST_FILL;
         endcase
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_slot[k] <= '0;
         end else if (w_out_hs) begin
            // clear so a short next batch sees zero in its unused slots
            r_slot[k] <= '0;
         end else if (w_in_hs && (r_count == CW'(k))) begin
            r_slot[k] <= i_in_data;
         end
      end
   end

   always_comb begin
      for (int b = 0; b < 4; b++) w_bus[b] = '0;
      for (int k = 0; k < N; k++) begin
         w_bus[slot_bus(k, N)][slot_lsb(k, N, M) +: M] = r_slot[k];
      end
   end

   assign o_add_a     = w_bus[0];
   assign o_add_b     = w_bus[1];
   assign o_add_c     = w_bus[2];
   assign o_add_d     = w_bus[3];
   assign o_add_c0    = 1'b0;
   assign o_out_valid = r_out_valid;
   assign o_out_sum   = r_out_sum;
   assign o_out_count = r_out_count;
   assign o_out_ovf   = r_out_ovf;
   assign o_busy      = (r_state != ST_FILL);

endmodule
